alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the datapath ALU: WIDTH-bit operands, 3-bit opcode
//  (add/sub/and/not-B plus shifts and pass-A), two registered stages with valid/ready flow
//  control, and a sticky status register. Sits between the register-file read port and the
//  writeback mux; back-pressure from writeback stalls the pipe without losing operations.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (>=4)
//  OPW     3   opcode width; fixed at 3, exposed for port sizing only
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      pipe can accept a beat this cycle
//  Ain        in   WIDTH  operand A
//  Bin        in   WIDTH  operand B
//  ALUop      in   OPW    operation select (table below)
//  loads      in   1      this op updates status on retirement
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result
//  out        out  WIDTH  result
//  status     out  SW     sticky flags {..,Z}; SW=1, or 3 ({V,N,Z}) with ALU_FLAGS_NV_EN
// BEHAVIOUR
//  Opcodes: 000 A+B; 001 A-B; 010 A&B; 011 ~B; 100 A<<1; 101 A>>1 (logical);
//   110 A>>>1 (arith, MSB replicated); 111 A. Add/sub wrap modulo 2^WIDTH, carry dropped.
//  Reset (async assert, sync release): s1_v=0, s2_v=0, out=0, out_valid=0, status=0,
//   in_ready=1 one cycle after release. Reset mid-operation discards all in-flight beats.
//  Stage 1 (S1): on in_valid&&in_ready, compute result and flags combinationally, register
//   {res, flags, loads}, s1_v<=1.
//  Stage 2 (S2): output register driving out/out_valid; S1 advances into S2 when
//   !s2_v || out_ready.
//  in_ready = !s1_v || !s2_v || out_ready (purely registered-state + out_ready, no in_valid path).
//  Latency: beat accepted at edge N appears on out at edge N+1 (visible cycle after),
//   retires at first edge with out_valid&&out_ready. Throughput 1 beat/cycle with out_ready=1.
//  Stall: out_valid=1 && out_ready=0 holds out stable; S1 fills, then in_ready=0.
//   No beat dropped, duplicated or reordered.
//  Simultaneous accept+retire with full pipe: S2<-S1, S1<-new beat, same edge.
//  out is don't-care-free: holds last value when out_valid=0.
//  Status: updated only at retirement edge of a beat with loads=1; Z=(res==0).
//   Beats with loads=0 leave status unchanged.
//  Flags computed on WIDTH-bit result; shifts of A=0 give Z=1.
// CONFIGURATION
//  ALU_FLAGS_NV_EN defined: status is 3 bits {V,N,Z}; N=res[WIDTH-1]; V set only for
//   000/001 on signed overflow (add: A,B same sign, res differs; sub: A,B differ, res sign != A);
//   V=0 for all other ops.
//  Undefined: status is 1 bit {Z}; no N/V logic synthesised.
// TESTING
//  WIDTH=16: A=3,B=3, ops 000..011 back-to-back, out_ready=1 -> out 6,0,3,0xFFFC on
//   4 consecutive cycles, latency 1 after accept; loads=1 on sub -> Z=1 after its retire.
//  A=0x8001: ops 100,101,110,111 -> 0x0002,0x4000,0xC000,0x8001.
//  Stall: 3 beats issued, out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, out held
//   at beat 0; release -> beats 0,1,2 retire in order, third accepted on release cycle.
//  Status gating: A=5,B=5 sub with loads=0 -> status unchanged (0); repeat with loads=1 -> Z=1.
//  ALU_FLAGS_NV_EN: A=0x7FFF,B=1 add -> out 0x8000, status {V,N,Z}=3'b110;
//   A=0x8000,B=1 sub -> 0x7FFF, 3'b100.
//  Reset with 2 beats in flight (reset_n low mid-cycle) -> out_valid=0, status=0 immediately;
//   neither beat retires after release.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready flow control and a sticky status register.
// Optional feature macro: ALU_FLAGS_NV_EN widens status to {V,N,Z}; undefined gives {Z} only.
module alu_pipe #(
   parameter int WIDTH = 16,
   parameter int OPW   = 3,
`ifdef ALU_FLAGS_NV_EN
   localparam int SW   = 3
`else
   localparam int SW   = 1
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] Ain,
   input  logic [WIDTH-1:0] Bin,
   input  logic [OPW-1:0]   ALUop,
   input  logic             loads,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [SW-1:0]    status
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_NOTB = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_SAR  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   logic [WIDTH-1:0] res;
   logic [SW-1:0]    flags;

   logic             s1_v;
   logic [WIDTH-1:0] s1_res;
   logic [SW-1:0]    s1_flags;
   logic             s1_loads;

   logic             s2_v;
   logic [WIDTH-1:0] s2_res;
   logic [SW-1:0]    s2_flags;
   logic             s2_loads;

   logic accept;
   logic s1_adv;
   logic retire;

   always_comb begin
      res = '0;
      case (ALUop[2:0])
         OP_ADD:  res = Ain + Bin;
         OP_SUB:  res = Ain - Bin;
         OP_AND:  res = Ain & Bin;
         OP_NOTB: res = ~Bin;
         OP_SHL:  res = {Ain[WIDTH-2:0], 1'b0};
         OP_SHR:  res = {1'b0, Ain[WIDTH-1:1]};
         OP_SAR:  res = {Ain[WIDTH-1], Ain[WIDTH-1:1]};
         OP_PASS: res = Ain;
         default: res = '0;
      endcase
   end

`ifdef ALU_FLAGS_NV_EN
   logic ovf;

   // Signed overflow only has meaning for add/sub; every other op reports V=0.
   always_comb begin
      ovf = 1'b0;
      if (ALUop[2:0] == OP_ADD)
         ovf = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
      else if (ALUop[2:0] == OP_SUB)
         ovf = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
   end

   assign flags = {ovf, res[WIDTH-1], (res == '0)};
`else
   assign flags = (res == '0);
`endif

   // in_ready depends only on registered state and out_ready, never on in_valid.
   assign in_ready = !s1_v || !s2_v || out_ready;
   assign accept   = in_valid && in_ready;
   assign s1_adv   = s1_v && (!s2_v || out_ready);
   assign retire   = s2_v && out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_v     <= 1'b0;
         s1_res   <= '0;
         s1_flags <= '0;
         s1_loads <= 1'b0;
      end else if (accept) begin
         s1_v     <= 1'b1;
         s1_res   <= res;
         s1_flags <= flags;
         s1_loads <= loads;
      end else if (s1_adv) begin
         s1_v     <= 1'b0;
      end
   end

   // Data registers only load on advance, so out holds its last value when idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_v     <= 1'b0;
         s2_res   <= '0;
         s2_flags <= '0;
         s2_loads <= 1'b0;
      end else if (s1_adv) begin
         s2_v     <= 1'b1;
         s2_res   <= s1_res;
         s2_flags <= s1_flags;
         s2_loads <= s1_loads;
      end else if (retire) begin
         s2_v     <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         status <= '0;
      else if (retire && s2_loads)
         status <= s2_flags;
   end

   assign out_valid = s2_v;
   assign out       = s2_res;

endmodule
